adc128s_spi_master: RTL and testbench

- SPI master that reads one 12-bit conversion from an ADC128S-style 8-channel serial ADC.
- On a start request it runs two back-to-back 16-bit SPI frames:
  - Frame 1 addresses the requested channel.
  - Frame 2 clocks out that channel's conversion.
- The block sits between system control logic (e.g. the pot/level sampling FSM) and the off-chip ADC pins.

---
 rtl/adc_spi_pkg.sv | 22 ++
 rtl/spi_frame_engine.sv | 78 +++++++
 rtl/adc128s_spi_master.sv | 96 +++++++++
 tb/tb_adc128s_spi_master.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_pkg.sv
// Shared types and constants for the ADC128S SPI master.
// Holds the sequencer state enum and the command-word builder.
package adc_spi_pkg;

  localparam int FRAME_BITS  = 16;
  localparam int RESULT_BITS = 12;

  typedef enum logic [2:0] {
    IDLE,
    XFER1,
    GAP,
    XFER2,
    DONE
  } state_t;

  function automatic logic [FRAME_BITS-1:0] cmd_word(
    input logic [2:0] ch
  );
    return {2'b00, ch, 11'h000};
  endfunction

endpackage

// File: rtl/spi_frame_engine.sv
// One 16-bit SPI frame: SCLK divider, shift register, edge count, SS_n.
// Started by a one-clock start pulse; reports completion with a done pulse.
module spi_frame_engine
  import adc_spi_pkg::*;
#(
  parameter int SCLK_DIV = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [FRAME_BITS-1:0]  cmd,
  input  logic                   miso,
  output logic                   sclk,
  output logic                   ss_n,
  output logic                   mosi,
  output logic                   done,
  output logic [RESULT_BITS-1:0] rx_data
);

  localparam int DW = $clog2(SCLK_DIV);
  localparam logic [DW-1:0] CNT_LOAD = DW'(SCLK_DIV * 3 / 4 - 1);
  localparam logic [DW-1:0] CNT_RISE = DW'(SCLK_DIV / 2 - 1);
  localparam logic [DW-1:0] CNT_MAX  = '1;
  localparam logic [4:0]    LAST_EDGE = 5'(FRAME_BITS);

  logic                  run;
  logic [DW-1:0]         cnt;
  logic [4:0]            rises;
  logic [FRAME_BITS-1:0] sh;

  assign rx_data = sh[RESULT_BITS-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run   <= 1'b0;
      cnt   <= '0;
      rises <= '0;
      sh    <= '0;
      sclk  <= 1'b1;
      ss_n  <= 1'b1;
      mosi  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!run) begin
        sclk <= 1'b1;
        mosi <= 1'b0;
        if (start) begin
          run   <= 1'b1;
          ss_n  <= 1'b0;
          cnt   <= CNT_LOAD;
          rises <= '0;
          sh    <= cmd;
        end
      end else begin
        cnt <= cnt + 1'b1;
        // after the last rising edge SCLK stays high for the back porch
        if (rises == LAST_EDGE) begin
          if (cnt == CNT_MAX) begin
            run  <= 1'b0;
            ss_n <= 1'b1;
            done <= 1'b1;
            mosi <= 1'b0;
          end
        end else if (cnt == CNT_MAX) begin
          sclk <= 1'b0;
          mosi <= sh[FRAME_BITS-1];
          sh   <= {sh[FRAME_BITS-2:0], 1'b0};
        end else if (cnt == CNT_RISE) begin
          sclk  <= 1'b1;
          sh[0] <= miso;
          rises <= rises + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adc128s_spi_master.sv
// Two-frame ADC128S conversion sequencer around spi_frame_engine.
// Define ADC_SINGLE_XFER_EN for a single pipelined frame per request.
module adc128s_spi_master
  import adc_spi_pkg::*;
#(
  parameter int SCLK_DIV = 32,
  parameter int GAP_CLKS = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             channel,
  input  logic                   start_cnv,
  output logic [RESULT_BITS-1:0] result,
  output logic                   cnv_complete,
  input  logic                   MISO,
  output logic                   MOSI,
  output logic                   SCLK,
  output logic                   SS_n
);

  localparam int GW = $clog2(GAP_CLKS + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLKS - 3);

  state_t                 state;
  logic [2:0]             ch_q;
  logic [GW-1:0]          gap_cnt;
  logic                   eng_start;
  logic                   eng_done;
  logic [RESULT_BITS-1:0] eng_rx;

  spi_frame_engine #(
    .SCLK_DIV(SCLK_DIV)
  ) u_eng (
    .clk     (clk),
    .rst     (rst),
    .start   (eng_start),
    .cmd     (cmd_word(ch_q)),
    .miso    (MISO),
    .sclk    (SCLK),
    .ss_n    (SS_n),
    .mosi    (MOSI),
    .done    (eng_done),
    .rx_data (eng_rx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ch_q         <= '0;
      gap_cnt      <= '0;
      eng_start    <= 1'b0;
      result       <= '0;
      cnv_complete <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_cnv) begin
            ch_q         <= channel;
            cnv_complete <= 1'b0;
            eng_start    <= 1'b1;
`ifdef ADC_SINGLE_XFER_EN
            state        <= XFER2;
`else
            state        <= XFER1;
`endif
          end
        end
        XFER1: begin
          if (eng_done) begin
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          // start is issued early so SS_n stays high GAP_CLKS clocks
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GAP_LAST) begin
            eng_start <= 1'b1;
            state     <= XFER2;
          end
        end
        XFER2: begin
          if (eng_done) state <= DONE;
        end
        DONE: begin
          result       <= eng_rx;
          cnv_complete <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc128s_spi_master.sv
// Scoreboard bench for adc128s_spi_master with an ADC128S-style model.
module tb_adc128s_spi_master;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  channel = '0;
  logic        start_cnv = 1'b0;
  logic [11:0] result;
  logic        cnv_complete;
  logic        miso_r = 1'b0;
  logic        MOSI;
  logic        SCLK;
  logic        SS_n;

  int errors = 0;
  int checks = 0;
  int frames = 0;

  logic [11:0] adc_val [8];
  logic [11:0] exp_q [$];
  logic [2:0]  addr_q [$];
  req_t        req_q [$];

  adc128s_spi_master dut (
    .clk          (clk),
    .rst          (rst),
    .channel      (channel),
    .start_cnv    (start_cnv),
    .result       (result),
    .cnv_complete (cnv_complete),
    .MISO         (miso_r),
    .MOSI         (MOSI),
    .SCLK         (SCLK),
    .SS_n         (SS_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ADC model and monitor share one process so all checks live here
  logic        ss_q = 1'b1;
  logic        sclk_q = 1'b1;
  logic        cc_q = 1'b0;
  logic [2:0]  cap = '0;
  logic [2:0]  cur_addr = '0;
  logic [15:0] word = '0;
  int          rises = 0;
  int          nf = 0;

  always @(negedge clk) begin
    req_t r;
    while (req_q.size() != 0) begin
      r = req_q.pop_front();
      check(r.name, r.act, r.exp);
    end
    if (ss_q && !SS_n) begin
      rises = 0;
      cap = '0;
      nf = 0;
      word = {4'h0, adc_val[cur_addr]};
    end
    if (!SS_n && sclk_q && !SCLK) begin
      if (nf < 16) miso_r = word[15-nf];
      nf++;
    end
    if (!SS_n && !sclk_q && SCLK) begin
      rises++;
      if (rises >= 3 && rises <= 5) cap = {cap[1:0], MOSI};
    end
    if (!ss_q && SS_n && !rst) begin
      frames++;
      check("frame_rises", rises, 16);
      if (addr_q.size() == 0) check("frame_unexpected", 1, 0);
      else check("frame_addr", {29'b0, cap}, {29'b0, addr_q.pop_front()});
      cur_addr = cap;
    end
    if (!cc_q && cnv_complete) begin
      if (exp_q.size() == 0) check("result_unexpected", 1, 0);
      else check("result", {20'b0, result}, {20'b0, exp_q.pop_front()});
    end
    ss_q = SS_n;
    sclk_q = SCLK;
    cc_q = cnv_complete;
  end

  task automatic post(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
    req_q.push_back('{nm, act, exp});
  endtask

  task automatic do_conv(input logic [2:0] ch, input int busy_ch);
    int f0;
    int n;
    exp_q.push_back(adc_val[ch]);
    addr_q.push_back(ch);
    addr_q.push_back(ch);
    f0 = frames;
    @(negedge clk);
    channel = ch;
    start_cnv = 1'b1;
    @(negedge clk);
    start_cnv = 1'b0;
    post("cc_cleared", {31'b0, cnv_complete}, 0);
    n = 1;
    while (!cnv_complete && n < 1100) begin
      @(negedge clk);
      n++;
      if (busy_ch >= 0 && n == 300) begin
        channel = 3'(busy_ch);
        start_cnv = 1'b1;
      end else begin
        start_cnv = 1'b0;
      end
    end
    start_cnv = 1'b0;
    post("latency_le_1100", {31'b0, cnv_complete}, 1);
    post("frames_per_cnv", frames - f0, 2);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) adc_val[i] = 12'h100 + 12'(i);

    repeat (5) @(negedge clk);
    post("rst_ss_n", {31'b0, SS_n}, 1);
    post("rst_sclk", {31'b0, SCLK}, 1);
    post("rst_result", {20'b0, result}, 0);
    post("rst_cc", {31'b0, cnv_complete}, 0);
    post("rst_mosi", {31'b0, MOSI}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // abort the first frame with a reset
    channel = 3'd2;
    start_cnv = 1'b1;
    @(negedge clk);
    start_cnv = 1'b0;
    repeat (200) @(negedge clk);
    post("mid_ss_low", {31'b0, SS_n}, 0);
    rst = 1'b1;
    #1;
    post("mid_ss_n", {31'b0, SS_n}, 1);
    post("mid_sclk", {31'b0, SCLK}, 1);
    post("mid_result", {20'b0, result}, 0);
    post("mid_cc", {31'b0, cnv_complete}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    adc_val[1] = 12'hABC;
    do_conv(3'd1, -1);
    adc_val[1] = 12'h101;

    for (int c = 0; c < 8; c++) do_conv(3'(c), -1);

    do_conv(3'd3, 5);

    repeat (500) @(negedge clk);
    post("cc_hold", {31'b0, cnv_complete}, 1);
    post("result_hold", {20'b0, result}, 12'h103);

    adc_val[6] = 12'hF0F;
    do_conv(3'd6, -1);

    repeat (5) @(negedge clk);
    post("sb_result_left", exp_q.size(), 0);
    post("sb_addr_left", addr_q.size(), 0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
